fp_alu_host_seq: RTL

FP_ALU_HOST_SEQ -- requirements
Module: fp_alu_host_seq

---
 rtl/fp_alu_host_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fp_alu_host_seq.sv
// Host-side sequencer: frames {hdr, a, b} as 9 bytes toward an FP ALU, collects a 4-byte result.
// Optional RECV watchdog enabled by defining FP_ALU_HOST_SEQ_TIMEOUT_EN.
module fp_alu_host_seq #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q, cap;
    logic [3:0]  idx;
    logic        tx_fire, rx_fire, last_tx, last_rx, timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign tx_valid = (state == SEND);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign tx_fire  = tx_valid && tx_ready;
    assign rx_fire  = (state == RECV) && rx_valid;
    assign last_tx  = (idx == 4'd8);
    assign last_rx  = (idx == 4'd3);

`ifdef FP_ALU_HOST_SEQ_TIMEOUT_EN
    logic [7:0] wdog;

    // Fires on the silent cycle whose increment would reach the limit.
    assign timeout = (state == RECV) && !rx_valid &&
                     (wdog + 8'd1 == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wdog <= '0;
        else if (state != RECV || rx_valid || timeout)
            wdog <= '0;
        else
            wdog <= wdog + 8'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign err = timeout;

    always_comb begin
        tx_data = '0;
        if (state == SEND) begin
            case (idx)
                4'd0:    tx_data = {6'b101000, op_q};
                4'd1:    tx_data = a_q[31:24];
                4'd2:    tx_data = a_q[23:16];
                4'd3:    tx_data = a_q[15:8];
                4'd4:    tx_data = a_q[7:0];
                4'd5:    tx_data = b_q[31:24];
                4'd6:    tx_data = b_q[23:16];
                4'd7:    tx_data = b_q[15:8];
                4'd8:    tx_data = b_q[7:0];
                default: tx_data = '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEND;
            SEND:    if (tx_fire && last_tx) state_nxt = RECV;
            RECV: begin
                if (timeout)                state_nxt = IDLE;
                else if (rx_fire && last_rx) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            cap    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    a_q  <= a;
                    b_q  <= b;
                    idx  <= '0;
                end
                SEND: if (tx_fire) idx <= last_tx ? 4'd0 : idx + 4'd1;
                RECV: if (rx_fire) begin
                    cap <= {cap[23:0], rx_data};
                    idx <= last_rx ? 4'd0 : idx + 4'd1;
                end
                DONE: result <= cap;
                default: ;
            endcase
        end
    end

endmodule
